// File: rtl/patch_matrix_xfade_if.sv
// Bus bundle for patch_matrix_xfade: sources, selects and routed outputs.
// gain_bus exists only when PATCH_MATRIX_GAIN_EN is defined.
interface patch_matrix_xfade_if #(
    parameter int BITSIZE = 16,
    parameter int N_IN    = 12,
    parameter int N_OUT   = 12,
    parameter int SELW    = 4
);
    logic                     sample_en;
    logic [N_IN*BITSIZE-1:0]  in_bus;
    logic [N_OUT*SELW-1:0]    sel_bus;
`ifdef PATCH_MATRIX_GAIN_EN
    logic [N_OUT*8-1:0]       gain_bus;
`endif
    logic [N_OUT*BITSIZE-1:0] out_bus;
    logic                     out_valid;
    logic                     busy;
    logic                     overrun;

    modport master (
        output sample_en, in_bus, sel_bus,
`ifdef PATCH_MATRIX_GAIN_EN
        output gain_bus,
`endif
        input  out_bus, out_valid, busy, overrun
    );

    modport slave (
        input  sample_en, in_bus, sel_bus,
`ifdef PATCH_MATRIX_GAIN_EN
        input  gain_bus,
`endif
        output out_bus, out_valid, busy, overrun
    );
endinterface

// File: rtl/patch_matrix_xfade.sv
// N_IN x N_OUT routing matrix with per-output linear crossfade on selection change.
// Optional Q1.7 per-output gain with saturation under PATCH_MATRIX_GAIN_EN.
module patch_matrix_xfade #(
    parameter int BITSIZE   = 16,
    parameter int N_IN      = 12,
    parameter int N_OUT     = 12,
    parameter int SELW      = 4,
    parameter int RAMP_LOG2 = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    patch_matrix_xfade_if.slave  bus
);
    localparam int R  = 1 << RAMP_LOG2;
    localparam int KW = RAMP_LOG2 + 1;
    localparam int PW = BITSIZE + RAMP_LOG2 + 2;
`ifdef PATCH_MATRIX_GAIN_EN
    localparam int STAGES = 3;
    localparam int GW     = BITSIZE + 9;
    localparam logic signed [GW-1:0] SAT_HI = GW'((1 << (BITSIZE-1)) - 1);
    localparam logic signed [GW-1:0] SAT_LO = GW'(-(1 << (BITSIZE-1)));
`else
    localparam int STAGES = 2;
`endif
    localparam int CW = $clog2(N_OUT + STAGES);
    localparam int JW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic [CW-1:0]   SWEEP_LAST = CW'(N_OUT + STAGES - 2);
    localparam logic [SELW-1:0] SILENCE    = SELW'(N_IN);
    localparam logic [KW-1:0]   K_FULL     = KW'(R);

    typedef enum logic [1:0] {IDLE, CAPTURE, SWEEP, DONE} state_t;
    state_t state, state_nx;

    logic [CW-1:0] cnt;
    logic          busy, out_valid, overrun, issue;

    logic [N_IN-1:0][BITSIZE-1:0]  in_cap;
    logic [N_OUT-1:0][SELW-1:0]    sel_cap, cur_sel, tgt_sel;
    logic [N_OUT-1:0][KW-1:0]      k;
    logic [N_OUT-1:0]              ramping;
    logic [N_OUT-1:0][BITSIZE-1:0] out_r;
    logic [STAGES-2:0]             vld_pipe;

    // FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        busy      = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:    if (bus.sample_en) state_nx = CAPTURE;
            CAPTURE: begin busy = 1'b1; state_nx = SWEEP; end
            SWEEP:   begin busy = 1'b1; if (cnt == SWEEP_LAST) state_nx = DONE; end
            DONE:    begin out_valid = 1'b1; state_nx = IDLE; end
            default: state_nx = IDLE;
        endcase
    end

    assign issue = (state == SWEEP) && (cnt < CW'(N_OUT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            overrun <= 1'b0;
            in_cap  <= '0;
            sel_cap <= '0;
        end else begin
            cnt <= (state == SWEEP) ? cnt + 1'b1 : '0;
            if (bus.sample_en && busy) overrun <= 1'b1;
            if (state == CAPTURE) begin
                in_cap  <= bus.in_bus;
                sel_cap <= bus.sel_bus;
            end
        end
    end

    // Stage 1: per-output fade bookkeeping and operand fetch
    logic [JW-1:0]              f_j;
    logic [SELW-1:0]            f_sel, f_cur, f_tgt;
    logic [KW-1:0]              k_nx;
    logic                       f_ramp, start, finish;
    logic signed [BITSIZE-1:0]  f_a, f_b;

    always_comb begin
        f_j    = cnt[JW-1:0];
        f_sel  = sel_cap[f_j];
        f_cur  = cur_sel[f_j];
        f_ramp = ramping[f_j];
        start  = !f_ramp && (f_sel != f_cur);
        f_tgt  = start ? f_sel : tgt_sel[f_j];
        k_nx   = start ? KW'(1) : (f_ramp ? k[f_j] + 1'b1 : '0);
        finish = f_ramp && (k_nx == K_FULL);
        f_a    = '0;
        f_b    = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (f_cur == SELW'(i)) f_a = in_cap[i];
            if (f_tgt == SELW'(i)) f_b = in_cap[i];
        end
    end

    logic signed [BITSIZE-1:0] s1_a, s1_b;
    logic [KW-1:0]             s1_k;
    logic [JW-1:0]             s1_j;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_sel <= {N_OUT{SILENCE}};
            tgt_sel <= {N_OUT{SILENCE}};
            k       <= '0;
            ramping <= '0;
            s1_a    <= '0;
            s1_b    <= '0;
            s1_k    <= '0;
            s1_j    <= '0;
        end else if (issue) begin
            s1_a <= f_a;
            s1_b <= f_b;
            s1_k <= k_nx;
            s1_j <= f_j;
            if (start) begin
                tgt_sel[f_j] <= f_sel;
                k[f_j]       <= KW'(1);
                ramping[f_j] <= 1'b1;
            end else if (finish) begin
                cur_sel[f_j] <= f_tgt;
                k[f_j]       <= '0;
                ramping[f_j] <= 1'b0;
            end else if (f_ramp) begin
                k[f_j] <= k_nx;
            end
        end
    end

    // Stage 2: a*(R-k) + b*k folded into a*R + (b-a)*k so one multiplier suffices
    logic signed [BITSIZE:0]   mix_diff;
    logic signed [PW-1:0]      mix_prod, mix_acc;
    logic signed [BITSIZE-1:0] mix_y;

    always_comb begin
        mix_diff = {s1_b[BITSIZE-1], s1_b} - {s1_a[BITSIZE-1], s1_a};
        mix_prod = PW'(mix_diff) * $signed({{(PW-KW){1'b0}}, s1_k});
        mix_acc  = mix_prod + (PW'(s1_a) <<< RAMP_LOG2);
        mix_y    = BITSIZE'(mix_acc >>> RAMP_LOG2);
    end

`ifdef PATCH_MATRIX_GAIN_EN
    logic [N_OUT-1:0][7:0]     gain_cap;
    logic signed [BITSIZE-1:0] s2_y, g_y;
    logic [JW-1:0]             s2_j;
    logic signed [GW-1:0]      g_prod, g_shr;

    always_comb begin
        g_prod = GW'(s2_y) * $signed({{(GW-8){1'b0}}, gain_cap[s2_j]});
        g_shr  = g_prod >>> 7;
        if (g_shr > SAT_HI)      g_y = BITSIZE'(SAT_HI);
        else if (g_shr < SAT_LO) g_y = BITSIZE'(SAT_LO);
        else                     g_y = BITSIZE'(g_shr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gain_cap <= '0;
            s2_y     <= '0;
            s2_j     <= '0;
            vld_pipe <= '0;
            out_r    <= '0;
        end else begin
            if (state == CAPTURE) gain_cap <= bus.gain_bus;
            vld_pipe <= {vld_pipe[0], issue};
            if (vld_pipe[0]) begin
                s2_y <= mix_y;
                s2_j <= s1_j;
            end
            if (vld_pipe[1]) out_r[s2_j] <= g_y;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            out_r    <= '0;
        end else begin
            vld_pipe[0] <= issue;
            if (vld_pipe[0]) out_r[s1_j] <= mix_y;
        end
    end
`endif

    assign bus.out_bus   = out_r;
    assign bus.out_valid = out_valid;
    assign bus.busy      = busy;
    assign bus.overrun   = overrun;
endmodule

// File: tb/tb_patch_matrix_xfade.sv
// Randomized + directed bench for patch_matrix_xfade against a frame-level fade model.
module tb_patch_matrix_xfade;
    localparam int BITSIZE = 16, N_IN = 12, N_OUT = 12, SELW = 4, RAMP_LOG2 = 6;
    localparam int R = 1 << RAMP_LOG2;
`ifdef PATCH_MATRIX_GAIN_EN
    localparam int LAT = N_OUT + 4;
`else
    localparam int LAT = N_OUT + 3;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    patch_matrix_xfade_if #(.BITSIZE(BITSIZE), .N_IN(N_IN), .N_OUT(N_OUT), .SELW(SELW)) bus ();

    patch_matrix_xfade #(
        .BITSIZE(BITSIZE), .N_IN(N_IN), .N_OUT(N_OUT), .SELW(SELW), .RAMP_LOG2(RAMP_LOG2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0, n_err = 0;
    int src_v [N_IN];
    int sel_v [N_OUT];
    int m_from [N_OUT], m_to [N_OUT], m_step [N_OUT];
    bit m_fading [N_OUT];
    int exp_y [N_OUT];
    int f_lat, f_busy, f_valid;

    task automatic chk(input string tag, input logic signed [31:0] got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int srcval(input int s);
        return (s < N_IN) ? src_v[s] : 0;
    endfunction

    function automatic logic signed [31:0] out_of(input int j);
        return $signed(bus.out_bus[j*BITSIZE +: BITSIZE]);
    endfunction

    task automatic model_reset();
        for (int j = 0; j < N_OUT; j++) begin
            m_from[j] = N_IN; m_to[j] = N_IN; m_step[j] = 0; m_fading[j] = 0;
        end
    endtask

    // One frame: a fade sits at step 1..R between two sources; selection is
    // only looked at again once the fade has fully landed.
    task automatic model_frame();
        for (int j = 0; j < N_OUT; j++) begin
            if (!m_fading[j] && sel_v[j] != m_from[j]) begin
                m_fading[j] = 1; m_to[j] = sel_v[j]; m_step[j] = 0;
            end
            if (m_fading[j]) begin
                m_step[j]++;
                exp_y[j] = (srcval(m_from[j]) * (R - m_step[j]) + srcval(m_to[j]) * m_step[j]) >>> RAMP_LOG2;
                if (m_step[j] == R) begin m_from[j] = m_to[j]; m_fading[j] = 0; end
            end else begin
                exp_y[j] = srcval(m_from[j]);
            end
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N_IN; i++)  bus.in_bus[i*BITSIZE +: BITSIZE] = BITSIZE'(src_v[i]);
        for (int j = 0; j < N_OUT; j++) bus.sel_bus[j*SELW +: SELW]     = SELW'(sel_v[j]);
`ifdef PATCH_MATRIX_GAIN_EN
        bus.gain_bus = {N_OUT{8'h80}};
`endif
    endtask

    // Strobe, watch a fixed window; extra_at>0 fires a second strobe that many cycles later.
    task automatic frame(input int extra_at);
        drive_inputs();
        @(negedge clk);
        bus.sample_en = 1'b1;
        f_lat = -1; f_busy = 0; f_valid = 0;
        for (int n = 1; n <= LAT + 9; n++) begin
            @(negedge clk);
            if (n == 1 || n == extra_at + 1) bus.sample_en = 1'b0;
            if (n == extra_at) bus.sample_en = 1'b1;
            if (bus.busy) f_busy++;
            if (bus.out_valid) begin
                f_valid++;
                if (f_lat < 0) f_lat = n;
            end
        end
        model_frame();
    endtask

    task automatic check_outs(input string tag);
        for (int j = 0; j < N_OUT; j++) chk($sformatf("%s out%0d", tag, j), out_of(j), exp_y[j]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.sample_en = 1'b0;
        for (int i = 0; i < N_IN; i++)  src_v[i] = 0;
        for (int j = 0; j < N_OUT; j++) sel_v[j] = N_IN;
        drive_inputs();
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset out_valid", bus.out_valid, 0);
        chk("reset busy", bus.busy, 0);
        chk("reset overrun", bus.overrun, 0);
        chk("reset out0", out_of(0), 0);
        chk("reset out11", out_of(N_OUT-1), 0);
        rst = 1'b0;

        // all outputs silenced while every source is live
        for (int i = 0; i < N_IN; i++) src_v[i] = int'($urandom_range(1, 30000));
        frame(0);
        chk("latency", f_lat, LAT);
        chk("busy cycles", f_busy, LAT - 1);
        chk("valid pulses", f_valid, 1);
        check_outs("silence");

        // fade in from silence to +16000
        src_v[0] = 16000; sel_v[0] = 0;
        for (int f = 1; f <= 70; f++) begin
            frame(0);
            chk($sformatf("fadein f%0d", f), out_of(0), (f <= R) ? 16000 * f / R : 16000);
            check_outs("fadein");
        end

        // crossfade to -16000, mid-ramp reselect deferred until the ramp lands
        src_v[1] = -16000; src_v[2] = 8000; sel_v[0] = 1;
        for (int f = 1; f <= 80; f++) begin
            if (f == 10) sel_v[0] = 2;
            frame(0);
            if (f <= R) chk($sformatf("xfade f%0d", f), out_of(0), 16000 - 32000 * f / R);
            else        chk($sformatf("refade f%0d", f), out_of(0), -16000 + 24000 * (f - R) / R);
            check_outs("xfade");
        end

        // random sources and selection churn, including silence codes
        for (int f = 0; f < 150; f++) begin
            for (int i = 0; i < N_IN; i++) src_v[i] = int'($urandom_range(0, 65535)) - 32768;
            for (int j = 0; j < N_OUT; j++)
                if ($urandom_range(0, 7) == 0) sel_v[j] = int'($urandom_range(0, 15));
            frame(0);
            check_outs($sformatf("rand f%0d", f));
        end
        chk("no overrun yet", bus.overrun, 0);

        // strobe while busy
        frame(5);
        chk("overrun set", bus.overrun, 1);
        chk("overrun valid pulses", f_valid, 1);
        chk("overrun latency", f_lat, LAT);
        check_outs("overrun");
        frame(0);
        chk("overrun sticky", bus.overrun, 1);
        check_outs("post overrun");

        // reset while the sweep is on output 5 mid-ramp
        for (int j = 0; j < N_OUT; j++) sel_v[j] = N_IN;
        src_v[1] = 12345; sel_v[5] = 1;
        repeat (3) begin frame(0); check_outs("pre reset"); end
        drive_inputs();
        @(negedge clk); bus.sample_en = 1'b1;
        @(negedge clk); bus.sample_en = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midreset busy", bus.busy, 0);
        chk("midreset out_valid", bus.out_valid, 0);
        chk("midreset overrun", bus.overrun, 0);
        for (int j = 0; j < N_OUT; j++) chk($sformatf("midreset out%0d", j), out_of(j), 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        src_v[3] = 20000; sel_v[5] = 3;
        frame(0);
        chk("after reset latency", f_lat, LAT);
        chk("after reset k1 out5", out_of(5), 20000 * 1 / R);
        check_outs("after reset");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/patch_matrix_xfade.md
Name: patch_matrix_xfade

Overview:
Parametrised successor to the fixed 12x12 signal-routing matrix in the synth top level. It routes any of N_IN audio sources to each of N_OUT sinks. On a selection change it performs a click-free linear crossfade over 2^RAMP_LOG2 samples instead of switching hard. One shared multiplier is time-multiplexed across outputs in the system clock domain, and processing is triggered by a per-frame sample strobe derived from LRCLK.

Parameters:
BITSIZE, 16, signed sample width.
N_IN, 12, number of source channels (1..15).
N_OUT, 12, number of sink channels (1..16).
SELW, 4, selector width per output; selector values >= N_IN select silence.
RAMP_LOG2, 6, crossfade length is 2^RAMP_LOG2 samples (1..10).

Ports:
clk  input  1  system clock (OSC domain)
rst  input  1  asynchronous, active-high reset
sample_en  input  1  one-cycle strobe per audio frame; must be synchronous to clk
in_bus  input  N_IN*BITSIZE  signed sources; channel i occupies bits [i*BITSIZE +: BITSIZE]
sel_bus  input  N_OUT*SELW  per-output source select; output j occupies bits [j*SELW +: SELW]
out_bus  output  N_OUT*BITSIZE  signed routed samples, registered
out_valid  output  1  one-cycle pulse when all outputs of a frame have been updated
busy  output  1  high while a sweep is in progress
overrun  output  1  sticky; set when sample_en arrives while busy

Behaviour:
- Reset values: out_bus=0, out_valid=0, busy=0, overrun=0, all internal counters=0.
- Per-output reset state: cur_sel=N_IN (silence), pending=0. The first real selection therefore fades in from silence.
- FSM states: IDLE, CAPTURE, SWEEP, DONE.
- IDLE -> CAPTURE on sample_en. CAPTURE lasts 1 cycle and snapshots in_bus and sel_bus into registers; busy=1 from this cycle.
- SWEEP processes output j = 0..N_OUT-1, one per cycle, through a 2-stage pipeline (operand fetch, multiply-add/writeback).
- DONE lasts 1 cycle: out_valid=1, busy deasserts, then the FSM returns to IDLE.
- Latency: out_valid rises N_OUT+3 cycles after sample_en. Minimum spacing between sample_en strobes is N_OUT+4 cycles.
- Per-output crossfade state: cur_sel, tgt_sel, k (RAMP_LOG2+1 bits), ramping flag.
- Starting a fade: in SWEEP, if not ramping and the captured sel != cur_sel, set tgt_sel=sel, k=1, ramping=1.
- Fade output: y = (src(cur_sel)*(R-k) + src(tgt_sel)*k) >>> RAMP_LOG2, where R=2^RAMP_LOG2. The product is signed, BITSIZE+RAMP_LOG2+2 bits wide, with arithmetic shift and truncation. No saturation is needed because the weights sum to R.
- Fade progress: k increments once per frame. When k reaches R, y = src(tgt_sel) exactly, cur_sel<=tgt_sel, and ramping clears.
- Steady state: when not ramping, y = src(cur_sel) with no rounding error.
- Selection change mid-ramp: the new value is not applied. It is re-evaluated on the first frame after the ramp completes, which then starts a new ramp from tgt_sel. A selection that returns to the original value mid-ramp still finishes the ramp, then ramps back.
- Silence: sel >= N_IN contributes 0 as a source; fades to and from silence are legal.
- sample_en while busy: the strobe is ignored, overrun latches to 1 until rst, and the current sweep completes unaffected.
- Reset mid-sweep: all outputs clear immediately (asynchronous), and ramps are abandoned.
- N_IN=1 and N_OUT=1 must elaborate correctly.

Optional Feature:
PATCH_MATRIX_GAIN_EN
- Enabled: adds input port gain_bus, N_OUT*8 bits, unsigned Q1.7 per output (0x80 = unity). Gain is captured together with sel_bus in CAPTURE.
- The post-crossfade sample is multiplied by the gain, arithmetically shifted by 7, and saturated to the signed BITSIZE range.
- This adds one pipeline stage, so latency becomes N_OUT+4 cycles and minimum strobe spacing becomes N_OUT+5 cycles.
- Disabled: no gain_bus port, unity gain, no saturation logic, latency as specified above.

Test Plan:
- Reset, then hold all sel=N_IN with in_bus nonzero and pulse sample_en -> every output is 0. out_valid appears exactly 15 cycles after the strobe (N_OUT=12); busy is high for 14 cycles.
- Set out0 sel=0 with in0=+16000 constant -> out0 over frames 1..64 = 16000*k/64, i.e. 250, 500, ..., 16000. It holds 16000 from frame 64 onward with cur_sel=0.
- Fade out0 from in0=+16000 to in1=-16000 (RAMP_LOG2=6) -> frame 32 = 0, frame 64 = -16000, sequence monotonic. A change of sel to 2 at frame 10 has no effect until frame 65, and the ramp to in2 starts at frame 65.
- Issue a second sample_en 5 cycles after the first -> overrun=1 and stays 1. Outputs equal the single-strobe result, with only one out_valid pulse.
- Assert rst during SWEEP at output 5 mid-ramp -> out_bus=0 and busy=0 immediately. The next frame with sel=3 fades in from silence starting at k=1.
- With PATCH_MATRIX_GAIN_EN, in0=+30000, gain=0xFF, steady state -> out0 = +32767 (saturated). With gain=0x40 -> out0 = +15000.
